// File: rtl/shift_left_sequencer.sv
// Sequential left shifter: latches A/B on START, shifts one bit per clock for
// min(B, N) cycles, then presents OUT/OVERFLOW with a one-cycle DONE strobe.
module shift_left_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out,
  output logic         overflow
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Shift amounts of N or more all clear the word, so clamp rather than wrap.
  function automatic logic [CW-1:0] sat_amount(input logic [N-1:0] amt);
    if (amt >= N'(N))
      sat_amount = CW'(N);
    else
      sat_amount = CW'(amt);
  endfunction

  logic [1:0]    state;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          ovf_acc;
  logic [CW-1:0] amt_sat;

  assign amt_sat = sat_amount(b);
  assign busy    = (state == ST_SHIFT);
  assign done    = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      acc      <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            acc     <= a;
            cnt     <= amt_sat;
            ovf_acc <= 1'b0;
            if (amt_sat == '0) begin
              state    <= ST_DONE;
              out      <= a;
              overflow <= 1'b0;
            end else begin
              state <= ST_SHIFT;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          ovf_acc <= ovf_acc | acc[N-1];
          acc     <= {acc[N-2:0], 1'b0};
          cnt     <= cnt - 1'b1;
          // Last shift: publish the post-shift value directly.
          if (cnt == CW'(1)) begin
            state    <= ST_DONE;
            out      <= {acc[N-2:0], 1'b0};
            overflow <= ovf_acc | acc[N-1];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_left_sequencer.sv
// Directed testbench for shift_left_sequencer (N = 8): vector table plus
// hand-written back-to-back and reset sequences.
module tb_shift_left_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic       overflow;

  int nvec;
  int nerr;
  logic [7:0] prev_out;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       ovf;
    int         s;
  } vec_t;

  vec_t tv [11];

  shift_left_sequencer #(.N(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int   lat;
    int   busy_n;
    logic hold_ok;
    logic both;
    logic got;
    @(negedge clk);
    a = v.a;
    b = v.b;
    start = 1'b1;
    lat = 0;
    busy_n = 0;
    hold_ok = 1'b1;
    both = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) start = 1'b0;
      if (busy && done) both = 1'b1;
      if (done) begin
        got = 1'b1;
        lat = k;
      end else begin
        if (busy) busy_n++;
        if (out !== prev_out) hold_ok = 1'b0;
      end
    end
    chk("latency", 32'(lat), 32'(v.s + 1));
    chk("out", 32'(out), 32'(v.out));
    chk("overflow", 32'(overflow), 32'(v.ovf));
    chk("busy_cycles", 32'(busy_n), 32'(v.s));
    chk("out_hold", 32'(hold_ok), 32'(1));
    chk("busy_with_done", 32'(both), 32'(0));
    prev_out = v.out;
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'(0));
    chk("out_after_done", 32'(out), 32'(v.out));
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    prev_out = 8'h00;
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;

    tv[0]  = '{8'h0B, 8'h01, 8'h16, 1'b0, 1};
    tv[1]  = '{8'h2B, 8'h03, 8'h58, 1'b1, 3};
    tv[2]  = '{8'h45, 8'h05, 8'hA0, 1'b1, 5};
    tv[3]  = '{8'h8B, 8'h25, 8'h00, 1'b1, 8};
    tv[4]  = '{8'h80, 8'h00, 8'h80, 1'b0, 0};
    tv[5]  = '{8'hFF, 8'h08, 8'h00, 1'b1, 8};
    tv[6]  = '{8'h01, 8'h07, 8'h80, 1'b0, 7};
    tv[7]  = '{8'hC0, 8'h02, 8'h00, 1'b1, 2};
    tv[8]  = '{8'h03, 8'h06, 8'hC0, 1'b0, 6};
    tv[9]  = '{8'h81, 8'h01, 8'h02, 1'b1, 1};
    tv[10] = '{8'h00, 8'hFF, 8'h00, 1'b0, 8};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_out", 32'(out), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));

    for (int i = 0; i < 11; i++) run_op(tv[i]);

    // START held high: one result every 3 cycles; A/B wiggled mid-SHIFT.
    @(negedge clk);
    a = 8'h01;
    b = 8'h02;
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) begin
        a = 8'hFF;
        b = 8'h07;
      end
      if (k == 5) begin
        a = 8'h01;
        b = 8'h02;
      end
      chk("b2b_done", 32'(done), 32'((k % 3) == 0));
      chk("b2b_busy", 32'(busy), 32'((k % 3) != 0));
      if (done) begin
        chk("b2b_out", 32'(out), 32'h04);
        chk("b2b_ovf", 32'(overflow), 32'(0));
      end
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_idle_done", 32'(done), 32'(0));
    chk("b2b_idle_busy", 32'(busy), 32'(0));

    // Reset during the second SHIFT cycle aborts the operation.
    @(negedge clk);
    a = 8'h2B;
    b = 8'h03;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_abort_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_out", 32'(out), 32'(0));
    chk("abort_ovf", 32'(overflow), 32'(0));
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk);
        #1;
        if (done || busy) seen = 1'b1;
      end
      chk("no_done_after_abort", 32'(seen), 32'(0));
    end

    // RST together with START: the request is dropped.
    @(negedge clk);
    a = 8'h0B;
    b = 8'h00;
    start = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (done || busy) seen = 1'b1;
        @(posedge clk);
        #1;
      end
      chk("rst_beats_start", 32'(seen), 32'(0));
      chk("rst_beats_start_out", 32'(out), 32'(0));
    end

    prev_out = 8'h00;
    run_op(tv[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/shift_left_sequencer.md
# shift_left_sequencer

Multi-cycle controller for the ALU's left-shift function. On a START pulse it latches operands A and B, then shifts one bit per clock through an internal accumulator for min(B, N) cycles. It accumulates an overflow flag and presents OUT/OVERFLOW with a one-cycle DONE strobe. It sequences the shift as an area-cheap alternative to a combinational barrel shifter, and sits behind the ALU operation decoder, which drives START and waits for DONE.

## Interface
- N, default 8: operand/result width in bits; N ≥ 2.
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset, synchronous, active-high.
- START  input  1  request; sampled on rising edge; honoured only in IDLE or DONE state.
- A  input  N  value to shift; sampled with accepted START only.
- B  input  N  shift amount, unsigned; sampled with accepted START only.
- BUSY  output  1  high while in SHIFT state.
- DONE  output  1  one-cycle strobe; result valid.
- OUT  output  N  shifted result, registered.
- OVERFLOW  output  1  high if any 1 bit was shifted out of bit N-1, registered.

## Operation
- One clock CLK; reset RST is synchronous and active-high.
- States: IDLE, SHIFT, DONE. RST forces IDLE on the next edge, regardless of current state.
- Internal registers:
  - acc[N-1:0]
  - cnt, $clog2(N+1) bits: remaining shifts
  - ovf_acc: 1 bit
- Accepted START (IDLE or DONE) performs the following, then enters SHIFT, or DONE directly if cnt would be 0:
  - acc ← A
  - cnt ← min(B, N): B ≥ N saturates to N; no modulo wrap.
  - ovf_acc ← 0
- SHIFT, each cycle:
  - ovf_acc ← ovf_acc | acc[N-1]
  - acc ← {acc[N-2:0], 1'b0}
  - cnt ← cnt-1
  - When cnt = 1 in this cycle, the next state is DONE.
- Entering DONE: OUT ← final acc and OVERFLOW ← final ovf_acc. These are the only cycles OUT/OVERFLOW change, apart from reset.
- DONE lasts exactly one cycle:
  - With START high, a new operation is accepted (back-to-back).
  - Otherwise the next state is IDLE.
- START while in SHIFT is ignored, with no queuing. A/B changes outside an accepted START have no effect.
- Result semantics, with s = min(B, N):
  - OUT = (A << s) truncated to N bits.
  - OVERFLOW = ((A >> (N-s)) != 0) for s > 0; OVERFLOW = 0 for s = 0.
  - s = N gives OUT = 0 and OVERFLOW = (A != 0).
- OUT/OVERFLOW hold the last result through IDLE and through the following operation's SHIFT cycles.

## Timing
- Reset values: state IDLE, BUSY 0, DONE 0, OUT 0, OVERFLOW 0, acc 0, cnt 0, ovf_acc 0.
- Latency: counting the edge that samples START as edge 1, DONE, OUT and OVERFLOW become valid after edge s+1.
  - B = 0: 1 edge.
  - B = 3: 4 edges.
  - B ≥ N: N+1 edges.
- BUSY is high for exactly s cycles. It is never high together with DONE.
- Throughput: back-to-back START in the DONE cycle gives one result every s+1 cycles with no idle gap.
- RST concurrent with START: RST wins and the operation is not accepted.
- RST mid-SHIFT: the operation is aborted, no DONE is produced, and all outputs take reset values after that edge.

## Test plan
- Reset, then A=0x0B, B=0x01, START for 1 cycle:
  - BUSY is high for 1 cycle.
  - DONE follows at edge 2 with OUT=0x16, OVERFLOW=0.
  - OUT stays 0x00 until then.
- A=0x2B, B=0x03 → DONE at edge 4, OUT=0x58, OVERFLOW=1. A=0x45, B=0x05 → DONE at edge 6, OUT=0xA0, OVERFLOW=1.
- Saturation: A=0x8B, B=0x25 → BUSY for 8 cycles, DONE at edge 9, OUT=0x00, OVERFLOW=1. Zero shift: A=0x80, B=0x00 → DONE at edge 1, BUSY never high, OUT=0x80, OVERFLOW=0.
- START held high continuously with A=0x01, B=0x02:
  - DONE pulses every 3 cycles, each with OUT=0x04, OVERFLOW=0.
  - A=0xFF, B=0x07 pulsed during SHIFT is ignored; the in-flight result is unchanged.
- RST asserted in the 2nd SHIFT cycle of A=0x2B, B=0x03:
  - The next edge gives BUSY=0, DONE=0, OUT=0x00, OVERFLOW=0.
  - No DONE appears afterward.
  - A subsequent START with A=0x0B, B=0x01 completes normally with OUT=0x16.
